// File: rtl/fp16_pkg.sv
// Shared fp16 constants and the FSM state type for the block accumulator.
// Imported by fp16_block_accum and fp16_normalize_pack.
package fp16_pkg;

    localparam int FP16_EXP_W   = 5;
    localparam int FP16_FRAC_W  = 10;
    localparam int FP16_EXP_MAX = 31;

    localparam logic [15:0] FP16_POS_INF = 16'h7C00;

    typedef enum logic [1:0] {
        ACCUM,
        NORM,
        EMIT
    } state_e;

endpackage

// File: rtl/fp16_normalize_pack.sv
// Combinational normalizer: turns the signed block accumulator and its exponent
// into one packed fp16 value (truncating, no subnormals, saturating to infinity).
module fp16_normalize_pack
    import fp16_pkg::*;
#(
    parameter int ACC_W = 20
) (
    input  logic signed [ACC_W-1:0]      acc_i,
    input  logic        [FP16_EXP_W-1:0] e_acc_i,
    input  logic                         ovf_i,
    output logic        [15:0]           data_o,
    output logic                         ovf_o
);

    logic             negative;
    logic [ACC_W-1:0] mag;
    logic [ACC_W-1:0] aligned;
    logic             unused_aligned;
    int               lead;
    int               expVal;

    // The most negative accumulator value negates to itself, which is still
    // the correct magnitude when read as unsigned.
    always_comb begin
        negative = acc_i[ACC_W-1];
        mag      = negative ? -acc_i : acc_i;
    end

    always_comb begin
        lead = 0;
        for (int i = 0; i < ACC_W; i++) begin
            if (mag[i]) begin
                lead = i;
            end
        end
    end

    // Leading one moves to the top bit; the fraction is the next FRAC_W bits.
    assign aligned        = mag << (ACC_W - 1 - lead);
    assign unused_aligned = ^{aligned[ACC_W-1], aligned[ACC_W-FP16_FRAC_W-2:0]};
    assign expVal         = int'(e_acc_i) + lead - FP16_FRAC_W;

    always_comb begin
        data_o = 16'h0000;
        ovf_o  = ovf_i;
        if (mag == '0) begin
            data_o = 16'h0000;
        end else if (expVal >= FP16_EXP_MAX) begin
            data_o = FP16_POS_INF | {negative, 15'b0};
            ovf_o  = 1'b1;
        end else if (expVal <= 0) begin
            data_o = {negative, 15'b0};
        end else begin
            data_o = {negative, expVal[FP16_EXP_W-1:0], aligned[ACC_W-2 -: FP16_FRAC_W]};
        end
    end

endmodule

// File: rtl/fp16_block_accum.sv
// Accumulates exponent-aligned mantissa quartets over a group of beats and
// emits one normalized fp16 result per group through a valid/ready output.
module fp16_block_accum
    import fp16_pkg::*;
#(
    parameter int ACC_W  = 20,
    parameter int MANT_W = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_last,
    input  logic [3:0]            in_signs,
    input  logic [FP16_EXP_W-1:0] in_exp,
    input  logic [MANT_W-1:0]     in_mant_a,
    input  logic [MANT_W-1:0]     in_mant_b,
    input  logic [MANT_W-1:0]     in_mant_c,
    input  logic [MANT_W-1:0]     in_mant_d,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [15:0]           out_data,
    output logic                  out_ovf
);

    localparam int QSUM_W = MANT_W + 3;

    state_e                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [FP16_EXP_W-1:0]   eAcc_q, eAcc_d;
    logic                    first_q, first_d;
    logic                    ovf_q, ovf_d;
    logic [15:0]             outData_q, outData_d;
    logic                    outOvf_q, outOvf_d;

    logic                    inFire;
    logic signed [QSUM_W-1:0] quartetSum;
    logic signed [ACC_W-1:0] quartetExt;
    logic signed [ACC_W-1:0] addA, addB;
    logic [FP16_EXP_W-1:0]   newExp;
    logic [ACC_W:0]          sumWide;
    logic                    sumOvf;
    logic signed [ACC_W-1:0] sumSat;
    logic [15:0]             packData;
    logic                    packOvf;

    function automatic logic signed [QSUM_W-1:0] signedMant(input logic neg,
                                                            input logic [MANT_W-1:0] m);
        logic signed [QSUM_W-1:0] v;
        v = $signed({{(QSUM_W-MANT_W){1'b0}}, m});
        return neg ? -v : v;
    endfunction

    // Shifts past the accumulator width collapse to the sign fill.
    function automatic logic signed [ACC_W-1:0] shiftRight(input logic signed [ACC_W-1:0] v,
                                                           input logic [FP16_EXP_W-1:0] amt);
        if (int'(amt) >= ACC_W) begin
            return {ACC_W{v[ACC_W-1]}};
        end
        return v >>> amt;
    endfunction

    assign inFire     = in_valid & in_ready;
    assign quartetSum = signedMant(in_signs[0], in_mant_a) + signedMant(in_signs[1], in_mant_b)
                      + signedMant(in_signs[2], in_mant_c) + signedMant(in_signs[3], in_mant_d);
    assign quartetExt = ACC_W'(quartetSum);

    // Whichever side carries the smaller exponent is shifted down before the add.
    always_comb begin
        if (in_exp > eAcc_q) begin
            addA   = shiftRight(acc_q, in_exp - eAcc_q);
            addB   = quartetExt;
            newExp = in_exp;
        end else begin
            addA   = acc_q;
            addB   = shiftRight(quartetExt, eAcc_q - in_exp);
            newExp = eAcc_q;
        end
    end

    assign sumWide = {addA[ACC_W-1], addA} + {addB[ACC_W-1], addB};
    assign sumOvf  = sumWide[ACC_W] ^ sumWide[ACC_W-1];
    assign sumSat  = sumOvf ? (sumWide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                              : {1'b0, {(ACC_W-1){1'b1}}})
                            : sumWide[ACC_W-1:0];

    fp16_normalize_pack #(
        .ACC_W (ACC_W)
    ) u_pack (
        .acc_i   (acc_q),
        .e_acc_i (eAcc_q),
        .ovf_i   (ovf_q),
        .data_o  (packData),
        .ovf_o   (packOvf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (inFire && in_last) state_d = NORM;
            NORM:    state_d = EMIT;
            EMIT:    if (out_ready) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ACCUM);
        out_valid = (state_q == EMIT);
    end

    always_comb begin
        acc_d     = acc_q;
        eAcc_d    = eAcc_q;
        first_d   = first_q;
        ovf_d     = ovf_q;
        outData_d = outData_q;
        outOvf_d  = outOvf_q;
        case (state_q)
            ACCUM: begin
                if (inFire) begin
                    if (first_q) begin
                        acc_d   = quartetExt;
                        eAcc_d  = in_exp;
                        first_d = 1'b0;
                    end else begin
                        acc_d  = sumSat;
                        eAcc_d = newExp;
                        ovf_d  = ovf_q | sumOvf;
                    end
                end
            end
            NORM: begin
                outData_d = packData;
                outOvf_d  = packOvf;
            end
            EMIT: begin
                if (out_ready) begin
                    first_d = 1'b1;
                    ovf_d   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            eAcc_q    <= '0;
            first_q   <= 1'b1;
            ovf_q     <= 1'b0;
            outData_q <= 16'h0000;
            outOvf_q  <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            eAcc_q    <= eAcc_d;
            first_q   <= first_d;
            ovf_q     <= ovf_d;
            outData_q <= outData_d;
            outOvf_q  <= outOvf_d;
        end
    end

    assign out_data = outData_q;
    assign out_ovf  = outOvf_q;

endmodule

// File: tb/tb_fp16_block_accum.sv
// Scoreboard bench for fp16_block_accum: directed cases plus random groups
// checked against an integer reference model of the accumulate/pack rules.
module tb_fp16_block_accum;

    localparam int     ACC_W   = 20;
    localparam longint ACC_MAX = (longint'(1) <<< (ACC_W - 1)) - 1;
    localparam longint ACC_MIN = -(longint'(1) <<< (ACC_W - 1));

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_last = 1'b0;
    logic [3:0]  in_signs = '0;
    logic [4:0]  in_exp = '0;
    logic [10:0] in_mant_a = '0, in_mant_b = '0, in_mant_c = '0, in_mant_d = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_ovf;

    always #5 clk = ~clk;

    fp16_block_accum #(
        .ACC_W  (ACC_W),
        .MANT_W (11)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .in_signs  (in_signs),
        .in_exp    (in_exp),
        .in_mant_a (in_mant_a),
        .in_mant_b (in_mant_b),
        .in_mant_c (in_mant_c),
        .in_mant_d (in_mant_d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    typedef struct {
        logic [15:0] data;
        logic        ovf;
        int          cyc;
    } expect_t;

    expect_t sbQ[$];
    int      testsRun = 0;
    int      testsFailed = 0;
    int      cyc = 0;
    int      lastXferCyc = 0;
    int      readyMode = 0;

    longint  mAcc = 0;
    int      mExp = 0;
    bit      mFirst = 1'b1;
    bit      mOvf = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference: value = acc * 2^(e-25); pack by finding the power of two and
    // scaling the magnitude so 1024 <= mant < 2048.
    function automatic void modelPack(input longint acc, input int e, input bit ovfIn,
                                      output logic [15:0] d, output bit ovf);
        bit     neg;
        longint mag, mant;
        int     p, bigE;
        neg = (acc < 0);
        mag = neg ? -acc : acc;
        ovf = ovfIn;
        if (mag == 0) begin
            d = 16'h0000;
        end else begin
            p = 0;
            while ((longint'(1) <<< (p + 1)) <= mag) p++;
            bigE = e + p - 10;
            if (bigE >= 31) begin
                d   = {neg, 15'h7C00};
                ovf = 1'b1;
            end else if (bigE <= 0) begin
                d = {neg, 15'h0000};
            end else begin
                mant = (mag * 1024) / (longint'(1) <<< p);
                d = {neg, 5'(bigE), 10'(mant % 1024)};
            end
        end
    endfunction

    function automatic longint floorShift(input longint v, input int k);
        return v >>> k;
    endfunction

    function automatic void modelBeat(input logic [3:0] s, input int e,
                                      input int a, input int b, input int c, input int d,
                                      input bit last, input bit pushModel);
        longint     q, sum;
        int         m[4];
        logic [15:0] pd;
        bit         po;
        m[0] = a; m[1] = b; m[2] = c; m[3] = d;
        q = 0;
        for (int k = 0; k < 4; k++) q += s[k] ? -longint'(m[k]) : longint'(m[k]);
        if (mFirst) begin
            mAcc   = q;
            mExp   = e;
            mFirst = 1'b0;
        end else begin
            if (e > mExp) begin
                sum  = floorShift(mAcc, e - mExp) + q;
                mExp = e;
            end else begin
                sum = mAcc + floorShift(q, mExp - e);
            end
            if (sum > ACC_MAX) begin
                sum  = ACC_MAX;
                mOvf = 1'b1;
            end else if (sum < ACC_MIN) begin
                sum  = ACC_MIN;
                mOvf = 1'b1;
            end
            mAcc = sum;
        end
        if (last) begin
            if (pushModel) begin
                modelPack(mAcc, mExp, mOvf, pd, po);
                sbQ.push_back('{pd, po, lastXferCyc});
            end
            mFirst = 1'b1;
            mOvf   = 1'b0;
        end
    endfunction

    task automatic applyStimulus(input logic [3:0] s, input int e,
                                 input int a, input int b, input int c, input int d,
                                 input bit last, input bit pushModel);
        bit done;
        in_signs  = s;
        in_exp    = 5'(e);
        in_mant_a = 11'(a);
        in_mant_b = 11'(b);
        in_mant_c = 11'(c);
        in_mant_d = 11'(d);
        in_last   = last;
        in_valid  = 1'b1;
        done      = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (in_ready) begin
                done        = 1'b1;
                lastXferCyc = cyc;
                modelBeat(s, e, a, b, c, d, last, pushModel);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) checkOutput("beat_accept_timeout", 0, 1);
    endtask

    task automatic expectResult(input logic [15:0] d, input logic o);
        sbQ.push_back('{d, o, lastXferCyc});
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (sbQ.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        if (sbQ.size() != 0) begin
            checkOutput("drain_timeout", sbQ.size(), 0);
            sbQ.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sbQ.delete();
        mAcc   = 0;
        mExp   = 0;
        mFirst = 1'b1;
        mOvf   = 1'b0;
    endtask

    task automatic checkResetState();
        @(negedge clk);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_out_data", out_data, 0);
        checkOutput("reset_out_ovf", out_ovf, 0);
        checkOutput("reset_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0:       out_ready = ($urandom_range(0, 3) != 0);
                1:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: pops on every output handshake, checks latency on the rising
    // edge of out_valid and stability while the consumer stalls.
    logic [16:0] prevData = '0;
    bit          prevHold = 1'b0;
    bit          prevValid = 1'b0;
    expect_t     exp;

    always @(negedge clk) begin
        if (rst) begin
            prevHold  = 1'b0;
            prevValid = 1'b0;
        end else begin
            if (out_valid) begin
                checkOutput("in_ready_low_while_emit", in_ready, 0);
                if (!prevValid && sbQ.size() != 0)
                    checkOutput("latency", cyc, sbQ[0].cyc + 2);
                if (prevHold)
                    checkOutput("hold_stable", {out_ovf, out_data}, prevData);
                if (out_ready) begin
                    if (sbQ.size() == 0) begin
                        checkOutput("unexpected_output", 1, 0);
                    end else begin
                        exp = sbQ.pop_front();
                        checkOutput("out_data", out_data, exp.data);
                        checkOutput("out_ovf", out_ovf, exp.ovf);
                    end
                    prevHold = 1'b0;
                end else begin
                    prevHold = 1'b1;
                    prevData = {out_ovf, out_data};
                end
            end else begin
                prevHold = 1'b0;
            end
            prevValid = out_valid;
        end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int n, base, e;
        bit handshake;
        doReset();
        checkResetState();

        readyMode = 2;
        applyStimulus(4'b0000, 15, 'h400, 'h400, 'h400, 'h400, 1'b1, 1'b0);
        expectResult(16'h4400, 1'b0);
        waitDrain();

        applyStimulus(4'b0010, 15, 'h400, 'h400, 0, 0, 1'b1, 1'b0);
        expectResult(16'h0000, 1'b0);
        waitDrain();

        applyStimulus(4'b0000, 15, 'h400, 0, 0, 0, 1'b0, 1'b0);
        applyStimulus(4'b0000, 16, 'h400, 0, 0, 0, 1'b1, 1'b0);
        expectResult(16'h4200, 1'b0);
        waitDrain();

        applyStimulus(4'b0000, 30, 'h7FF, 'h7FF, 'h7FF, 'h7FF, 1'b1, 1'b0);
        expectResult(16'h7C00, 1'b1);
        waitDrain();

        // Consumer stalls in EMIT while the next quartet is already offered.
        readyMode = 1;
        applyStimulus(4'b0000, 15, 'h400, 0, 0, 0, 1'b1, 1'b0);
        expectResult(16'h3C00, 1'b0);
        in_signs = 4'b0000; in_exp = 5'd16; in_mant_a = 11'h400;
        in_mant_b = '0; in_mant_c = '0; in_mant_d = '0; in_last = 1'b1;
        in_valid = 1'b1;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("stall_reached_emit", out_valid, 1);
        repeat (5) begin
            @(negedge clk);
            checkOutput("stall_in_ready", in_ready, 0);
            checkOutput("stall_out_valid", out_valid, 1);
        end
        @(posedge clk);
        #1;
        readyMode = 2;
        handshake = 1'b0;
        for (int k = 0; k < 20 && !handshake; k++) begin
            @(negedge clk);
            if (out_valid && out_ready) handshake = 1'b1;
        end
        checkOutput("stall_release_handshake", handshake, 1);
        @(negedge clk);
        checkOutput("accept_after_release", in_ready, 1);
        lastXferCyc = cyc;
        modelBeat(4'b0000, 16, 'h400, 0, 0, 0, 1'b1, 1'b0);
        expectResult(16'h4000, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        waitDrain();

        // Aborted group must leave no residue.
        readyMode = 0;
        applyStimulus(4'b0101, 20, 'h5A5, 'h7FF, 'h123, 'h400, 1'b0, 1'b1);
        applyStimulus(4'b0000, 22, 'h7FF, 'h7FF, 'h7FF, 'h7FF, 1'b0, 1'b1);
        doReset();
        checkResetState();
        applyStimulus(4'b0000, 15, 'h400, 0, 0, 0, 1'b1, 1'b0);
        expectResult(16'h3C00, 1'b0);
        waitDrain();

        // Long same-exponent groups drive the accumulator into saturation.
        for (int g = 0; g < 2; g++) begin
            for (int b = 0; b < 70; b++)
                applyStimulus(g == 0 ? 4'b0000 : 4'b1111, 5, 'h7FF, 'h7FF, 'h7FF, 'h7FF,
                              b == 69, 1'b1);
            waitDrain();
        end

        for (int g = 0; g < 60; g++) begin
            n    = $urandom_range(1, 6);
            base = $urandom_range(0, 31);
            for (int b = 0; b < n; b++) begin
                if (g % 4 == 0) e = $urandom_range(0, 31);
                else e = base + $urandom_range(0, 6) - 3;
                if (e < 0) e = 0;
                if (e > 31) e = 31;
                applyStimulus(4'($urandom_range(0, 15)), e,
                              $urandom_range(0, 2047), $urandom_range(0, 2047),
                              $urandom_range(0, 2047), $urandom_range(0, 2047),
                              b == n - 1, 1'b1);
            end
        end
        waitDrain();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/fp16_block_accum.md
Name: fp16_block_accum

Overview:
- Consumes one exponent-aligned quartet per beat from the alignment stage: four signs, a shared block exponent and four 11-bit mantissas with the hidden bit included.
- Forms the signed quartet sum and accumulates it across a multi-beat group, realigning as the block exponent changes.
- On the group's last beat, normalizes the total and packs it into one fp16 result.
- Sits between the alignment stage and the result writeback/FIFO, with valid/ready on both sides.

Parameters:
- ACC_W, 20, signed accumulator width in bits (two's complement); minimum 14.
- MANT_W, 11, aligned mantissa width including the hidden bit; fixed by the fp16 format.

Ports:
- clk  input  1  clock.
- rst  input  1  reset.
- in_valid  input  1  quartet present.
- in_ready  output  1  block accepts the quartet this cycle.
- in_last  input  1  final quartet of the group.
- in_signs  input  4  signs; bit0=a, bit1=b, bit2=c, bit3=d; 1 = negative.
- in_exp  input  5  shared block exponent of the quartet.
- in_mant_a / in_mant_b / in_mant_c / in_mant_d  input  11 each  aligned mantissas.
- out_valid  output  1  result held.
- out_ready  input  1  consumer accepts the result.
- out_data  output  16  packed fp16 result.
- out_ovf  output  1  accumulator saturated or exponent overflowed in this group; qualified by out_valid.

Behaviour:
- Single clock clk; reset rst is synchronous and active-high.
- Reset values:
  - state=ACCUM, first=1, acc=0, e_acc=0.
  - out_valid=0, out_data=0x0000, out_ovf=0.
  - in_ready=1 in the cycle after rst deasserts.
- Transfer rules: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
- States: ACCUM, NORM, EMIT.
  - ACCUM: in_ready=1.
    - Each transfer computes S = sum of (sign_i ? -m_i : +m_i), 14-bit signed, sign-extended to ACC_W.
    - If first=1: acc=S, e_acc=in_exp, first=0.
    - Else if in_exp > e_acc: acc = (acc >>> (in_exp-e_acc)) + S, e_acc=in_exp.
    - Else: acc = acc + (S >>> (e_acc-in_exp)).
    - Shifts are arithmetic and truncating. Shift amounts ≥ ACC_W yield 0 for non-negative operands and -1 for negative ones.
    - Addition overflow saturates acc to the signed max/min and sets the sticky ovf.
    - A transfer with in_last=1 moves to NORM.
  - NORM: in_ready=0; one cycle.
    - mag = |acc|; p = index of the leading one of mag.
    - mag==0: result 0x0000 (positive zero).
    - Otherwise: E = e_acc + p - 10. Mantissa = mag aligned so the leading one sits at bit 10, truncated toward zero; the stored fraction is bits 9:0.
    - E ≥ 31: ±inf (sign<<15 | 0x7C00), ovf=1.
    - E ≤ 0: signed zero (sign<<15). No subnormal output.
    - Register out_data and out_ovf, then go to EMIT.
  - EMIT: out_valid=1, in_ready=0.
    - out_data and out_ovf stay stable until the output transfer.
    - On transfer: out_valid=0, first=1, ovf=0, go to ACCUM.
    - The next quartet can be accepted the cycle after the transfer.
- Latency: last beat accepted at cycle t → out_valid=1 at t+2. Group throughput is N+2 cycles minimum for N beats.
- in_valid high in NORM/EMIT is not consumed. Input fields are sampled only on a transfer.
- rst at any point, including mid-group or mid-EMIT, discards the partial acc and any pending result and returns to the reset values.
- A single-beat group (in_last=1 on the first beat) is legal.
- in_exp=0 quartets are accumulated with no special casing.

Decomposition:
- Package fp16_pkg:
  - FP16_EXP_W=5, FP16_FRAC_W=10, FP16_EXP_MAX=31.
  - FP16_POS_INF=16'h7C00.
  - State enum {ACCUM, NORM, EMIT}.
- Sub-module fp16_normalize_pack (combinational): acc, e_acc, ovf_in → out_data, ovf_out. It contains the leading-one detector and the pack logic. The FSM and accumulator stay in fp16_block_accum.

Test Plan:
- One beat, in_last=1, in_exp=15, all mantissas 0x400, signs 0 → out_data=0x4400 (4.0), out_ovf=0, out_valid two cycles after the transfer.
- One beat, in_exp=15, a=+0x400, b=-0x400 (in_signs=4'b0010), c=d=0 → out_data=0x0000.
- Beat 1: in_exp=15, a=0x400, others 0. Beat 2 (last): in_exp=16, a=0x400, others 0. Expect acc realigned to 512+1024=1536 → out_data=0x4200 (3.0).
- One beat, in_exp=30, all mantissas 0x7FF positive → E=32 → out_data=0x7C00, out_ovf=1.
- out_ready held low 5 cycles in EMIT with in_valid=1 → out_data stable, in_ready=0, no input consumed. Release → the next quartet is accepted the following cycle.
- rst pulsed after 2 of 3 beats, then a fresh single-beat group (in_exp=15, a=0x400) → out_data=0x3C00 (1.0), no residue from the aborted group.
